pre_mac_egress_arbiter: RTL and testbench

- Shares the single pre-MAC egress stream among NUM_AXIS_ID virtual-interface AXI-Stream sources.
- Arbitrates round-robin at packet granularity and never interleaves beats of different packets.
- Stamps each packet with tid = source index and tuser = that source's configured route mask.
- Sits directly upstream of the MAC-side interface and replaces the constant all-ones route mask with per-source configuration.

---
 rtl/pre_mac_egress_arbiter_pkg.sv | 36 +++
 rtl/pre_mac_egress_arbiter_if.sv | 45 ++++
 rtl/pre_mac_egress_arbiter_skid.sv | 64 ++++++
 rtl/pre_mac_egress_arbiter.sv | 113 +++++++++++
 tb/tb_pre_mac_egress_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pre_mac_egress_arbiter_pkg.sv
// Shared types and helpers for the pre-MAC egress arbiter: FSM encodings and
// the round-robin pick used at packet boundaries.
package pre_mac_arb_pkg;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    // Upper bound on sources the round-robin helper can scan.
    localparam int unsigned MAX_SRC  = 64;
    localparam int unsigned MAX_ID_W = 6;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req searching upward from ptr+1, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                         input int unsigned ptr,
                                         input int unsigned n);
        rr_pick_t            r;
        int unsigned         cand;
        logic [MAX_ID_W-1:0] cand_id;
        r = '0;
        for (int unsigned off = 1; off <= MAX_SRC; off++) begin
            cand    = (ptr + off) % n;
            cand_id = MAX_ID_W'(cand);
            if (off <= n && !r.found && req[cand_id]) begin
                r.found = 1'b1;
                r.idx   = cand_id;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pre_mac_egress_arbiter_if.sv
// Bundle of per-source AXI-Stream inputs, per-source configuration, the
// single egress stream and the lock status of the arbiter.
interface pre_mac_egress_arbiter_if #(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int AXIS_ID_WIDTH  = 2
);
    localparam int NUM_AXIS_ID = 2 ** AXIS_ID_WIDTH;
    localparam int KEEP_W      = AXIS_BUS_WIDTH / 8;

    logic [NUM_AXIS_ID*AXIS_BUS_WIDTH-1:0] axis_in_tdata;
    logic [NUM_AXIS_ID*KEEP_W-1:0]         axis_in_tkeep;
    logic [NUM_AXIS_ID-1:0]                axis_in_tlast;
    logic [NUM_AXIS_ID-1:0]                axis_in_tvalid;
    logic [NUM_AXIS_ID-1:0]                axis_in_tready;

    logic [NUM_AXIS_ID-1:0]                cfg_src_enable;
    logic [NUM_AXIS_ID*NUM_AXIS_ID-1:0]    cfg_route_mask;

    logic [AXIS_BUS_WIDTH-1:0]             axis_out_tdata;
    logic [NUM_AXIS_ID-1:0]                axis_out_tuser;
    logic [AXIS_ID_WIDTH-1:0]              axis_out_tid;
    logic [KEEP_W-1:0]                     axis_out_tkeep;
    logic                                  axis_out_tlast;
    logic                                  axis_out_tvalid;
    logic                                  axis_out_tready;

    logic                                  pkt_active;

    modport slave (
        input  axis_in_tdata, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
        input  cfg_src_enable, cfg_route_mask, axis_out_tready,
        output axis_in_tready,
        output axis_out_tdata, axis_out_tuser, axis_out_tid, axis_out_tkeep,
        output axis_out_tlast, axis_out_tvalid, pkt_active
    );

    modport master (
        output axis_in_tdata, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
        output cfg_src_enable, cfg_route_mask, axis_out_tready,
        input  axis_in_tready,
        input  axis_out_tdata, axis_out_tuser, axis_out_tid, axis_out_tkeep,
        input  axis_out_tlast, axis_out_tvalid, pkt_active
    );

endinterface

// File: rtl/pre_mac_egress_arbiter_skid.sv
// Two-entry register slice: upstream ready depends only on the registered
// fill level, so the egress ready never reaches the source ready paths.
module axis_skid_reg #(
    parameter int DATA_W = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        count_q;
    logic [1:0]        count_n;
    logic              full_q;
    logic              push;
    logic              pop;

    assign s_ready = ~full_q;
    assign m_valid = (count_q != 2'd0);
    assign m_data  = head_q;
    assign push    = s_valid & ~full_q;
    assign pop     = m_valid & m_ready;

    always_comb begin
        count_n = count_q;
        if (push && !pop) begin
            count_n = count_q + 2'd1;
        end else if (pop && !push) begin
            count_n = count_q - 2'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_n;
            full_q  <= (count_n == 2'd2);
            // Push while full cannot happen, so only these cases move data.
            if (pop) begin
                if (count_q == 2'd2) begin
                    head_q <= tail_q;
                end else if (push) begin
                    head_q <= s_data;
                end
            end else if (push) begin
                if (count_q == 2'd0) begin
                    head_q <= s_data;
                end else begin
                    tail_q <= s_data;
                end
            end
        end
    end

endmodule

// File: rtl/pre_mac_egress_arbiter.sv
// Packet-granular round-robin arbiter merging per-source AXI-Stream inputs
// onto one egress stream, stamping tid and the per-source route mask.
module pre_mac_egress_arbiter
    import pre_mac_arb_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int AXIS_ID_WIDTH  = 2
) (
    input logic                     aclk,
    input logic                     areset,
    pre_mac_egress_arbiter_if.slave bus
);
    localparam int NUM_AXIS_ID = 2 ** AXIS_ID_WIDTH;
    localparam int KEEP_W      = AXIS_BUS_WIDTH / 8;
    localparam int PAY_W       = AXIS_BUS_WIDTH + KEEP_W + 1 + NUM_AXIS_ID + AXIS_ID_WIDTH;

    if (AXIS_BUS_WIDTH % 8 != 0) begin : g_bad_width
        $error("AXIS_BUS_WIDTH must be a multiple of 8");
    end
    if (AXIS_ID_WIDTH < 1 || AXIS_ID_WIDTH > MAX_ID_W) begin : g_bad_id
        $error("AXIS_ID_WIDTH out of range");
    end

    logic [0:0]                state_q;
    logic [AXIS_ID_WIDTH-1:0]  rr_ptr_q;
    logic [AXIS_ID_WIDTH-1:0]  grant_q;
    logic [NUM_AXIS_ID-1:0]    route_mask_q;

    logic [NUM_AXIS_ID-1:0]    req;
    rr_pick_t                  pick;
    logic [AXIS_ID_WIDTH-1:0]  pick_id;
    logic                      pick_unused;

    logic [AXIS_BUS_WIDTH-1:0] sel_tdata;
    logic [KEEP_W-1:0]         sel_tkeep;
    logic                      sel_tlast;
    logic                      sel_tvalid;
    logic                      beat_acc;
    logic [NUM_AXIS_ID-1:0]    in_ready;

    logic                      skid_ready;
    logic                      skid_valid;
    logic [PAY_W-1:0]          skid_in;
    logic [PAY_W-1:0]          skid_out;

    assign req         = bus.axis_in_tvalid & bus.cfg_src_enable;
    assign pick        = rr_pick(MAX_SRC'(req), 32'(rr_ptr_q), 32'(NUM_AXIS_ID));
    assign pick_id     = pick.idx[AXIS_ID_WIDTH-1:0];
    assign pick_unused = ^pick.idx;

    assign sel_tdata  = bus.axis_in_tdata[grant_q*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
    assign sel_tkeep  = bus.axis_in_tkeep[grant_q*KEEP_W +: KEEP_W];
    assign sel_tlast  = bus.axis_in_tlast[grant_q];
    assign sel_tvalid = bus.axis_in_tvalid[grant_q];
    assign beat_acc   = (state_q == LOCKED) & sel_tvalid & skid_ready;

    always_comb begin
        in_ready = '0;
        if (state_q == LOCKED) begin
            in_ready[grant_q] = skid_ready;
        end
    end

    assign bus.axis_in_tready = in_ready;
    assign bus.pkt_active     = (state_q == LOCKED);

    // Enable and route mask are sampled only here, so mid-packet changes
    // never disturb the packet in flight.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= {AXIS_ID_WIDTH{1'b1}};
            grant_q      <= '0;
            route_mask_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick.found) begin
                        grant_q      <= pick_id;
                        route_mask_q <= bus.cfg_route_mask[pick_id*NUM_AXIS_ID +: NUM_AXIS_ID];
                        state_q      <= LOCKED;
                    end
                end
                default: begin
                    if (beat_acc && sel_tlast) begin
                        rr_ptr_q <= grant_q;
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign skid_in = {sel_tdata, sel_tkeep, sel_tlast, route_mask_q, grant_q};

    axis_skid_reg #(
        .DATA_W (PAY_W)
    ) u_skid (
        .aclk    (aclk),
        .areset  (areset),
        .s_data  (skid_in),
        .s_valid (beat_acc),
        .s_ready (skid_ready),
        .m_data  (skid_out),
        .m_valid (skid_valid),
        .m_ready (bus.axis_out_tready)
    );

    assign {bus.axis_out_tdata, bus.axis_out_tkeep, bus.axis_out_tlast,
            bus.axis_out_tuser, bus.axis_out_tid} = skid_out;
    assign bus.axis_out_tvalid = skid_valid;

endmodule

// File: tb/tb_pre_mac_egress_arbiter.sv
// Scoreboard bench for pre_mac_egress_arbiter: sources feed per-source beat
// queues, expected egress beats are queued in arbitration order.
module tb_pre_mac_egress_arbiter;

    localparam int W   = 64;
    localparam int IDW = 2;
    localparam int N   = 4;
    localparam int KW  = 8;

    typedef struct {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic clk;
    logic areset;
    int   cyc = 0;

    pre_mac_egress_arbiter_if #(.AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW)) bus ();

    pre_mac_egress_arbiter #(.AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW)) dut (
        .aclk   (clk),
        .areset (areset),
        .bus    (bus)
    );

    beat_t          src_q [N][$];
    logic [127:0]   exp_q [$];
    logic [N-1:0]   mask_cfg [N];
    int             in_acc [N];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   t_rise  = -1;
    int   first_out_cyc = -1;
    int   occ = 0;
    int   max_occ = 0;
    int   idle_cnt = 0;
    logic gap_armed = 1'b0;
    logic last_was_tlast = 1'b0;
    logic check_gaps = 1'b0;
    logic bp_mode = 1'b0;
    logic stall_seen = 1'b0;
    logic saw_ready1 = 1'b0;
    logic active_seen = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_word(logic [W-1:0] d, logic [KW-1:0] k, logic l,
                                             logic [N-1:0] u, logic [IDW-1:0] id);
        return {49'd0, d, k, l, u, id};
    endfunction

    function automatic logic [127:0] out_word();
        return mk_word(bus.axis_out_tdata, bus.axis_out_tkeep, bus.axis_out_tlast,
                       bus.axis_out_tuser, bus.axis_out_tid);
    endfunction

    task automatic send_pkt(input int src, input int nbeats, input logic zero_keep);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.data = {$urandom, $urandom};
            b.keep = (zero_keep && k == 1) ? 8'h00 : 8'($urandom_range(1, 255));
            b.last = (k == nbeats - 1);
            src_q[src].push_back(b);
            exp_q.push_back(mk_word(b.data, b.keep, b.last, mask_cfg[src], IDW'(src)));
        end
    endtask

    task automatic wait_drain(input string tag);
        int left;
        left = 400;
        while (left > 0 && (exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
               src_q[2].size() != 0 || src_q[3].size() != 0 || bus.axis_out_tvalid || bus.pkt_active)) begin
            @(negedge clk);
            left--;
        end
        check({tag, "_drain"}, 128'(exp_q.size()), 128'd0);
    endtask

    // Source driver: handshakes sampled at the falling edge, next beats
    // presented just after the rising edge.
    initial begin
        logic [N-1:0] hs;
        logic         prev_any;
        logic         bp_pat [4];
        int           bp_idx;
        beat_t        b;
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bp_idx = 0;
        prev_any = 1'b0;
        bus.axis_in_tdata   = '0;
        bus.axis_in_tkeep   = '0;
        bus.axis_in_tlast   = '0;
        bus.axis_in_tvalid  = '0;
        bus.axis_out_tready = 1'b1;
        forever begin
            @(negedge clk);
            hs = areset ? '0 : (bus.axis_in_tvalid & bus.axis_in_tready);
            if (bus.axis_in_tready[1]) saw_ready1 = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() != 0) begin
                    b = src_q[i].pop_front();
                    in_acc[i]++;
                end
                if (src_q[i].size() != 0) begin
                    b = src_q[i][0];
                    bus.axis_in_tdata[i*W +: W]   = b.data;
                    bus.axis_in_tkeep[i*KW +: KW] = b.keep;
                    bus.axis_in_tlast[i]          = b.last;
                    bus.axis_in_tvalid[i]         = 1'b1;
                end else begin
                    bus.axis_in_tvalid[i] = 1'b0;
                end
            end
            if (!prev_any && (|bus.axis_in_tvalid)) t_rise = cyc;
            prev_any = |bus.axis_in_tvalid;
            if (bp_mode) begin
                bus.axis_out_tready = bp_pat[bp_idx % 4];
                bp_idx++;
            end else begin
                bus.axis_out_tready = 1'b1;
                bp_idx = 0;
            end
        end
    end

    // Egress monitor and scoreboard.
    initial begin
        logic         stall_hold;
        logic [127:0] stall_word;
        logic         in_hs;
        logic         out_hs;
        logic [127:0] e;
        stall_hold = 1'b0;
        stall_word = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                stall_hold = 1'b0;
                gap_armed  = 1'b0;
                occ        = 0;
                continue;
            end
            if (bus.pkt_active) active_seen = 1'b1;
            if (bus.axis_out_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
            if (stall_hold) begin
                check("stall_valid", 128'(bus.axis_out_tvalid), 128'd1);
                check("stall_hold", out_word(), stall_word);
            end
            in_hs  = |(bus.axis_in_tvalid & bus.axis_in_tready);
            out_hs = bus.axis_out_tvalid & bus.axis_out_tready;
            occ = occ + int'(in_hs) - int'(out_hs);
            if (occ > max_occ) max_occ = occ;
            if (out_hs) begin
                if (exp_q.size() == 0) begin
                    check("sb_pop_empty", 128'(exp_q.size()), 128'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", out_word(), e);
                end
                if (check_gaps && gap_armed)
                    check("gap", 128'(idle_cnt), last_was_tlast ? 128'd1 : 128'd0);
                gap_armed      = 1'b1;
                last_was_tlast = bus.axis_out_tlast;
                idle_cnt       = 0;
            end else if (!bus.axis_out_tvalid) begin
                idle_cnt++;
            end
            if (bus.axis_out_tvalid && !bus.axis_out_tready) stall_seen = 1'b1;
            stall_hold = bus.axis_out_tvalid & ~bus.axis_out_tready;
            stall_word = out_word();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int left;
        mask_cfg = '{4'b0110, 4'b1010, 4'b1100, 4'b0011};
        for (int i = 0; i < N; i++) in_acc[i] = 0;
        bus.cfg_src_enable = '1;
        for (int i = 0; i < N; i++) bus.cfg_route_mask[i*N +: N] = mask_cfg[i];
        areset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(bus.axis_out_tvalid), 128'd0);
        check("rst_in_ready", 128'(bus.axis_in_tready), 128'd0);
        check("rst_pkt_active", 128'(bus.pkt_active), 128'd0);
        check("rst_out_word", out_word(), 128'd0);
        @(posedge clk); #2;
        areset = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Round-robin from reset pointer: expected order 0,1,3,0,1,3.
        check_gaps = 1'b1;
        gap_armed  = 1'b0;
        send_pkt(0, 2, 1'b0); send_pkt(1, 2, 1'b0); send_pkt(3, 2, 1'b0);
        send_pkt(0, 2, 1'b0); send_pkt(1, 2, 1'b0); send_pkt(3, 2, 1'b0);
        wait_drain("rr");
        check_gaps = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        // Single source, latency and stamping.
        t_rise = -1;
        first_out_cyc = -1;
        active_seen = 1'b0;
        send_pkt(0, 3, 1'b0);
        wait_drain("single");
        check("single_latency", 128'(first_out_cyc - t_rise), 128'd2);
        check("single_active_seen", 128'(active_seen), 128'd1);
        repeat (3) @(posedge clk);
        #2;

        // Backpressure with a zero-keep beat.
        bp_mode = 1'b1;
        max_occ = 0;
        stall_seen = 1'b0;
        send_pkt(2, 4, 1'b1);
        wait_drain("bp");
        @(posedge clk); #2;
        bp_mode = 1'b0;
        check("bp_occ_over2", 128'(max_occ > 2), 128'd0);
        check("bp_stall_seen", 128'(stall_seen), 128'd1);
        repeat (3) @(posedge clk);
        #2;

        // Config change mid-packet.
        base = in_acc[1];
        send_pkt(1, 5, 1'b0);
        left = 200;
        while (left > 0 && in_acc[1] < base + 2) begin
            @(negedge clk);
            left--;
        end
        check("cfg_beat2_reached", 128'(in_acc[1] >= base + 2), 128'd1);
        bus.cfg_src_enable[1]   = 1'b0;
        bus.cfg_route_mask[4+:4] = 4'b0101;
        wait_drain("cfg");
        @(posedge clk); #2;
        saw_ready1  = 1'b0;
        active_seen = 1'b0;
        src_q[1].push_back('{data: 64'hDEAD_BEEF_0000_0001, keep: 8'hFF, last: 1'b1});
        repeat (20) @(negedge clk);
        check("cfg_no_regrant_ready", 128'(saw_ready1), 128'd0);
        check("cfg_no_regrant_active", 128'(active_seen), 128'd0);
        @(posedge clk); #2;
        src_q[1].delete();
        repeat (2) @(posedge clk);
        #2;
        bus.cfg_src_enable[1]    = 1'b1;
        bus.cfg_route_mask[4+:4] = mask_cfg[1];
        repeat (2) @(posedge clk);
        #2;

        // Reset mid-packet.
        base = in_acc[2];
        send_pkt(2, 4, 1'b0);
        left = 200;
        while (left > 0 && in_acc[2] < base + 2) begin
            @(negedge clk);
            left--;
        end
        check("rst_mid_beat2_reached", 128'(in_acc[2] >= base + 2), 128'd1);
        @(posedge clk); #2;
        areset = 1'b1;
        src_q[2].delete();
        exp_q.delete();
        @(posedge clk); #2;
        areset = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 128'(bus.axis_out_tvalid), 128'd0);
        check("rst_mid_in_ready", 128'(bus.axis_in_tready), 128'd0);
        check("rst_mid_pkt_active", 128'(bus.pkt_active), 128'd0);
        @(posedge clk); #2;
        send_pkt(1, 2, 1'b0);
        send_pkt(3, 2, 1'b0);
        wait_drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
